// File: rtl/count_sweep_ctrl.sv
// Sweep sequencer for a 4-bit up/down counter: seek to lo, then bounce lo<->hi with dwell.
// Optional `SWEEP_HOLD_EN adds a hold input that freezes the sequence.
module count_sweep_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DWELL_W = 4,
  parameter int TRIP_W  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   lo_lim,
  input  logic [WIDTH-1:0]   hi_lim,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [TRIP_W-1:0]  trips,
  input  logic [WIDTH-1:0]   cnt_in,
`ifdef SWEEP_HOLD_EN
  input  logic               hold,
`endif
  output logic               cnt_en,
  output logic               cnt_ud,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] SEEK     = 3'd1;
  localparam logic [2:0] UP       = 3'd2;
  localparam logic [2:0] DWELL_HI = 3'd3;
  localparam logic [2:0] DOWN     = 3'd4;
  localparam logic [2:0] DWELL_LO = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  logic [2:0]         state_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   hi_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [TRIP_W-1:0]  trips_r;
  logic [DWELL_W-1:0] dwell_cnt_r;
  logic [TRIP_W-1:0]  trip_cnt_r;
  logic               err_r;
  logic               hold_s;
  logic               en_s;
  logic               ud_s;
  logic [TRIP_W-1:0]  trip_nxt_s;

`ifdef SWEEP_HOLD_EN
  assign hold_s = hold;
`else
  assign hold_s = 1'b0;
`endif

  assign trip_nxt_s = trip_cnt_r + {{(TRIP_W-1){1'b0}}, 1'b1};

  // Sequencer state, latched sweep fields, dwell/trip counters and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      lo_r        <= {WIDTH{1'b0}};
      hi_r        <= {WIDTH{1'b0}};
      dwell_r     <= {DWELL_W{1'b0}};
      trips_r     <= {TRIP_W{1'b0}};
      dwell_cnt_r <= {DWELL_W{1'b0}};
      trip_cnt_r  <= {TRIP_W{1'b0}};
      err_r       <= 1'b0;
    end else if (abort) begin
      state_r <= IDLE;
    end else if (hold_s) begin
      state_r <= state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            if (hi_lim > lo_lim) begin
              lo_r       <= lo_lim;
              hi_r       <= hi_lim;
              dwell_r    <= dwell;
              trips_r    <= trips;
              trip_cnt_r <= {TRIP_W{1'b0}};
              err_r      <= 1'b0;
              state_r    <= SEEK;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        SEEK: begin
          if (cnt_in == lo_r) state_r <= UP;
        end
        UP: begin
          if (cnt_in == hi_r) begin
            dwell_cnt_r <= dwell_r;
            state_r     <= DWELL_HI;
          end
        end
        DWELL_HI: begin
          if (dwell_cnt_r == {DWELL_W{1'b0}}) state_r <= DOWN;
          else dwell_cnt_r <= dwell_cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
        end
        DOWN: begin
          if (cnt_in == lo_r) begin
            dwell_cnt_r <= dwell_r;
            state_r     <= DWELL_LO;
          end
        end
        DWELL_LO: begin
          if (dwell_cnt_r == {DWELL_W{1'b0}}) begin
            // trips == 0 runs forever; the trip counter simply wraps
            trip_cnt_r <= trip_nxt_s;
            if ((trips_r != {TRIP_W{1'b0}}) && (trip_nxt_s == trips_r)) state_r <= DONE;
            else state_r <= UP;
          end else begin
            dwell_cnt_r <= dwell_cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Counter drive: move toward the active limit and stop exactly on it.
  always_comb begin
    en_s = 1'b0;
    ud_s = 1'b0;
    case (state_r)
      SEEK: begin
        if (cnt_in > lo_r) begin
          en_s = 1'b1;
          ud_s = 1'b0;
        end else if (cnt_in < lo_r) begin
          en_s = 1'b1;
          ud_s = 1'b1;
        end else begin
          en_s = 1'b0;
          ud_s = 1'b0;
        end
      end
      UP: begin
        ud_s = 1'b1;
        en_s = (cnt_in != hi_r);
      end
      DOWN: begin
        ud_s = 1'b0;
        en_s = (cnt_in != lo_r);
      end
      default: begin
        en_s = 1'b0;
        ud_s = 1'b0;
      end
    endcase
  end

  // Abort and hold gate the enable so the counter never takes a step on that edge.
  always_comb begin
    cnt_en = en_s & ~abort & ~hold_s;
    cnt_ud = ud_s;
    busy   = (state_r != IDLE);
    done   = (state_r == DONE) & ~hold_s;
    err    = err_r;
  end

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Bench for count_sweep_ctrl: a behavioural 4-bit counter closes the loop around the DUT.
// Hold checks are compiled only when SWEEP_HOLD_EN is defined.
module tb_count_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] lo_lim, hi_lim, dwell, cnt;
  logic [2:0] trips;
  logic       cnt_en, cnt_ud, busy, done, err;
  logic       load;
  logic [3:0] load_val;
`ifdef SWEEP_HOLD_EN
  logic       hold;
`endif

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] c0, lo, hi, dw;
    logic [2:0] tr;
    logic       en1, ud1;
    int         done_at, hi_low;
  } vec_t;

  vec_t tv[6];

  always #5 clk = ~clk;

  // Counter under control: registered, moves one step per enabled edge.
  always @(posedge clk) begin
    if (load) cnt <= load_val;
    else if (cnt_en) cnt <= cnt_ud ? cnt + 4'd1 : cnt - 4'd1;
  end

  count_sweep_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .lo_lim(lo_lim), .hi_lim(hi_lim), .dwell(dwell), .trips(trips),
    .cnt_in(cnt),
`ifdef SWEEP_HOLD_EN
    .hold(hold),
`endif
    .cnt_en(cnt_en), .cnt_ud(cnt_ud), .busy(busy), .done(done), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_cnt(input logic [3:0] v);
    @(negedge clk);
    load = 1'b1;
    load_val = v;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic go(input logic [3:0] lo, input logic [3:0] hi, input logic [3:0] dw,
                    input logic [2:0] tr);
    @(negedge clk);
    lo_lim = lo; hi_lim = hi; dwell = dw; trips = tr; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_abort();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the start edge; the sweep ends when busy drops.
  task automatic run_vec(input int i);
    int cyc, done_at, dones, hi_low, mx, mn;
    logic reached;
    done_at = -1; dones = 0; hi_low = 0; mx = 0; mn = 15; reached = 1'b0;
    load_cnt(tv[i].c0);
    go(tv[i].lo, tv[i].hi, tv[i].dw, tv[i].tr);
    for (cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk($sformatf("v%0d_en1", i), cnt_en, tv[i].en1);
        chk($sformatf("v%0d_ud1", i), cnt_ud, tv[i].ud1);
      end
      if (!busy) break;
      if (done) begin dones++; done_at = cyc; end
      if (cnt == tv[i].lo) reached = 1'b1;
      if (reached) begin
        if (cnt > mx) mx = cnt;
        if (cnt < mn) mn = cnt;
      end
      if (cnt == tv[i].hi && !cnt_en) hi_low++;
    end
    chk($sformatf("v%0d_timeout", i), (cyc <= 300), 1'b1);
    chk($sformatf("v%0d_done_at", i), done_at, tv[i].done_at);
    chk($sformatf("v%0d_dones", i), dones, 1);
    chk($sformatf("v%0d_max", i), mx, tv[i].hi);
    chk($sformatf("v%0d_min", i), mn, tv[i].lo);
    chk($sformatf("v%0d_hi_low", i), hi_low, tv[i].hi_low);
    chk($sformatf("v%0d_end_cnt", i), cnt, tv[i].lo);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dones, idle_seen, desc, k;
    logic [3:0] prev;
    // Each sweep: SEEK |c0-lo|+1, per trip (hi-lo+1)+(dw+1) twice, then DONE.
    // Counter sits at hi with enable low for the arrival cycle plus dw+1 dwell cycles.
    tv[0] = '{c0:4'd9,  lo:4'd2, hi:4'd5,  dw:4'd0, tr:3'd1, en1:1'b1, ud1:1'b0, done_at:19, hi_low:2};
    tv[1] = '{c0:4'd0,  lo:4'd0, hi:4'd3,  dw:4'd2, tr:3'd2, en1:1'b0, ud1:1'b0, done_at:30, hi_low:8};
    tv[2] = '{c0:4'd15, lo:4'd1, hi:4'd4,  dw:4'd1, tr:3'd3, en1:1'b1, ud1:1'b0, done_at:52, hi_low:9};
    tv[3] = '{c0:4'd0,  lo:4'd0, hi:4'd15, dw:4'd0, tr:3'd1, en1:1'b0, ud1:1'b0, done_at:36, hi_low:2};
    tv[4] = '{c0:4'd7,  lo:4'd6, hi:4'd7,  dw:4'd3, tr:3'd7, en1:1'b1, ud1:1'b0, done_at:87, hi_low:35};
    tv[5] = '{c0:4'd1,  lo:4'd3, hi:4'd9,  dw:4'd1, tr:3'd1, en1:1'b1, ud1:1'b1, done_at:22, hi_low:3};

    rst = 1'b1; start = 1'b0; abort = 1'b0; load = 1'b1; load_val = 4'd7;
    lo_lim = 4'd0; hi_lim = 4'd0; dwell = 4'd0; trips = 3'd0;
`ifdef SWEEP_HOLD_EN
    hold = 1'b0;
`endif
    @(posedge clk);
    #1 load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_en", cnt_en, 1'b0);
    chk("rst_ud", cnt_ud, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", cnt, 4'd7);
    rst = 1'b0;

    // Bad limits: equal and inverted.
    go(4'd6, 4'd6, 4'd0, 3'd1);
    @(negedge clk);
    chk("bad_eq_err", err, 1'b1);
    chk("bad_eq_busy", busy, 1'b0);
    chk("bad_eq_done", done, 1'b0);
    go(4'd9, 4'd3, 4'd0, 3'd1);
    @(negedge clk);
    chk("bad_inv_err", err, 1'b1);
    chk("bad_inv_busy", busy, 1'b0);
    go(4'd1, 4'd4, 4'd0, 3'd1);
    @(negedge clk);
    chk("good_clr_err", err, 1'b0);
    chk("good_busy", busy, 1'b1);
    do_abort();

    // abort held together with a valid start keeps the FSM idle
    @(negedge clk);
    lo_lim = 4'd1; hi_lim = 4'd4; abort = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 begin abort = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("abort_blocks_start", busy, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Abort mid-UP at cnt 8: counter must stay at 8.
    load_cnt(4'd0);
    go(4'd0, 4'd15, 4'd0, 3'd0);
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (cnt == 4'd8) break;
      k++;
    end
    chk("abort_reach8", (k < 40), 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    dones = 0;
    @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_en", cnt_en, 1'b0);
    chk("abort_cnt", cnt, 4'd8);
    if (done) dones++;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_cnt_hold", cnt, 4'd8);

    // rst mid-UP: edge still applies that cycle's step (3 -> 4), then nothing moves.
    load_cnt(4'd0);
    go(4'd0, 4'd15, 4'd0, 3'd0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_en", cnt_en, 1'b0);
    chk("midrst_cnt", cnt, 4'd4);

    // Infinite mode: 100 cycles cover 12 descents to lo, trip counter wraps.
    load_cnt(4'd4);
    go(4'd4, 4'd6, 4'd0, 3'd0);
    dones = 0; idle_seen = 0; desc = 0; prev = 4'd0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) dones++;
      if (!busy) idle_seen++;
      if (prev == 4'd5 && cnt == 4'd4) desc++;
      prev = cnt;
    end
    chk("inf_no_done", dones, 0);
    chk("inf_busy", idle_seen, 0);
    chk("inf_descents", desc, 12);

`ifdef SWEEP_HOLD_EN
    // Hold mid-DOWN at cnt 5, then resume to 4.
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      if (cnt == 4'd5 && cnt_en && !cnt_ud) break;
      k++;
    end
    chk("hold_reach", (k < 40), 1'b1);
    hold = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_cnt", cnt, 4'd5);
      chk("hold_en", cnt_en, 1'b0);
      chk("hold_busy", busy, 1'b1);
    end
    hold = 1'b0;
    @(negedge clk);
    chk("hold_resume", cnt, 4'd4);
`endif
    do_abort();
    @(negedge clk);
    chk("final_idle", busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
